// File: rtl/shell_table_render.sv
// Shell table for the tank playfield: per-player slot banks with spawn/tick/kill
// updates, plus a two-stage colour lookup for the VGA scan.
module shell_table_render #(
    parameter int N_PLAYER = 2,
    parameter int N_SHELL  = 5,
    parameter int COORD_W  = 6,
    parameter int MAX_X    = 39,
    parameter int MAX_Y    = 29
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst_n,
    input  logic                                      i_spawn_valid,
    input  logic [$clog2(N_PLAYER)-1:0]               i_spawn_player,
    input  logic [COORD_W-1:0]                        i_spawn_x,
    input  logic [COORD_W-1:0]                        i_spawn_y,
    input  logic [1:0]                                i_spawn_dir,
    output logic                                      o_spawn_ready,
    input  logic                                      i_tick,
    input  logic                                      i_kill_valid,
    input  logic [$clog2(N_PLAYER)-1:0]               i_kill_player,
    input  logic [$clog2(N_SHELL)-1:0]                i_kill_slot,
    output logic [N_PLAYER*N_SHELL-1:0]               o_valid,
    output logic [N_PLAYER*N_SHELL*COORD_W-1:0]       o_shell_x,
    output logic [N_PLAYER*N_SHELL*COORD_W-1:0]       o_shell_y,
    output logic [N_PLAYER*$clog2(N_SHELL+1)-1:0]     o_count,
    input  logic [COORD_W-1:0]                        i_display_x,
    input  logic [COORD_W-1:0]                        i_display_y,
    input  logic                                      i_sprite_on,
    input  logic [N_PLAYER*24-1:0]                    i_palette,
    output logic [23:0]                               o_rgb
);
    localparam int NS = N_PLAYER * N_SHELL;
    localparam int CW = $clog2(N_SHELL + 1);
    localparam logic [COORD_W-1:0] LAST_X = COORD_W'(MAX_X);
    localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(MAX_Y);

    logic [NS-1:0]      r_valid;
    logic [COORD_W-1:0] r_x   [NS];
    logic [COORD_W-1:0] r_y   [NS];
    logic [1:0]         r_dir [NS];
    logic [CW-1:0]      r_count [N_PLAYER];
    logic [N_PLAYER-1:0] r_hit;
    logic               r_sprite;
    logic [23:0]        r_rgb;

    logic [NS-1:0]      w_valid_n;
    logic [COORD_W-1:0] w_x_n   [NS];
    logic [COORD_W-1:0] w_y_n   [NS];
    logic [1:0]         w_dir_n [NS];
    logic [CW-1:0]      w_count_n [N_PLAYER];
    logic [N_PLAYER-1:0] w_hit;
    logic [23:0]        w_rgb_n;
    logic               w_ready;
    logic               w_fire;
    int                 w_free_idx;

    // Spawn handshake: a request transfers on any edge where i_spawn_valid and
    // o_spawn_ready are both high; out-of-range coordinates are dropped after transfer.
    always_comb begin
        w_ready    = 1'b0;
        w_free_idx = 0;
        if (int'(i_spawn_player) < N_PLAYER) begin
            for (int s = N_SHELL - 1; s >= 0; s--) begin
                if (!r_valid[int'(i_spawn_player) * N_SHELL + s]) begin
                    w_ready    = 1'b1;
                    w_free_idx = int'(i_spawn_player) * N_SHELL + s;
                end
            end
        end
    end

    assign o_spawn_ready = w_ready;
    assign w_fire        = i_spawn_valid && w_ready;

    // Order matters: tick, then kill (kill beats tick), then spawn into a pre-update free slot.
    always_comb begin
        w_valid_n = r_valid;
        w_x_n     = r_x;
        w_y_n     = r_y;
        w_dir_n   = r_dir;
        if (i_tick) begin
            for (int i = 0; i < NS; i++) begin
                if (r_valid[i]) begin
                    case (r_dir[i])
                        2'd0: if (r_y[i] == '0) w_valid_n[i] = 1'b0;
                              else w_y_n[i] = r_y[i] - 1'b1;
                        2'd1: if (r_x[i] == LAST_X) w_valid_n[i] = 1'b0;
                              else w_x_n[i] = r_x[i] + 1'b1;
                        2'd2: if (r_y[i] == LAST_Y) w_valid_n[i] = 1'b0;
                              else w_y_n[i] = r_y[i] + 1'b1;
                        default: if (r_x[i] == '0) w_valid_n[i] = 1'b0;
                                 else w_x_n[i] = r_x[i] - 1'b1;
                    endcase
                end
            end
        end
        if (i_kill_valid && int'(i_kill_player) < N_PLAYER && int'(i_kill_slot) < N_SHELL) begin
            w_valid_n[int'(i_kill_player) * N_SHELL + int'(i_kill_slot)] = 1'b0;
        end
        if (w_fire && i_spawn_x <= LAST_X && i_spawn_y <= LAST_Y) begin
            w_valid_n[w_free_idx] = 1'b1;
            w_x_n[w_free_idx]     = i_spawn_x;
            w_y_n[w_free_idx]     = i_spawn_y;
            w_dir_n[w_free_idx]   = i_spawn_dir;
        end
        for (int p = 0; p < N_PLAYER; p++) begin
            w_count_n[p] = '0;
            for (int s = 0; s < N_SHELL; s++) begin
                w_count_n[p] = w_count_n[p] + CW'(w_valid_n[p * N_SHELL + s]);
            end
        end
    end

    always_comb begin
        w_hit = '0;
        for (int p = 0; p < N_PLAYER; p++) begin
            for (int s = 0; s < N_SHELL; s++) begin
                if (r_valid[p * N_SHELL + s] && r_x[p * N_SHELL + s] == i_display_x &&
                    r_y[p * N_SHELL + s] == i_display_y) begin
                    w_hit[p] = 1'b1;
                end
            end
        end
    end

    // Later players overwrite earlier ones, so the highest index wins.
    always_comb begin
        w_rgb_n = '0;
        if (r_sprite) begin
            for (int p = 0; p < N_PLAYER; p++) begin
                if (r_hit[p]) w_rgb_n = i_palette[p * 24 +: 24];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid  <= '0;
            r_hit    <= '0;
            r_sprite <= 1'b0;
            r_rgb    <= '0;
            for (int i = 0; i < NS; i++) begin
                r_x[i]   <= '0;
                r_y[i]   <= '0;
                r_dir[i] <= '0;
            end
            for (int p = 0; p < N_PLAYER; p++) r_count[p] <= '0;
        end else begin
            r_valid  <= w_valid_n;
            r_x      <= w_x_n;
            r_y      <= w_y_n;
            r_dir    <= w_dir_n;
            r_count  <= w_count_n;
            r_hit    <= w_hit;
            r_sprite <= i_sprite_on;
            r_rgb    <= w_rgb_n;
        end
    end

    always_comb begin
        o_valid = r_valid;
        o_rgb   = r_rgb;
        for (int i = 0; i < NS; i++) begin
            o_shell_x[i * COORD_W +: COORD_W] = r_x[i];
            o_shell_y[i * COORD_W +: COORD_W] = r_y[i];
        end
        for (int p = 0; p < N_PLAYER; p++) o_count[p * CW +: CW] = r_count[p];
    end

endmodule

// File: tb/tb_shell_table_render.sv
// Directed bench for shell_table_render: table-driven table updates, then
// hand-written render, reset and restart sequences.
module tb_shell_table_render;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spawn_valid = 1'b0;
    logic [0:0]  spawn_player = '0;
    logic [5:0]  spawn_x = '0, spawn_y = '0;
    logic [1:0]  spawn_dir = '0;
    logic        spawn_ready;
    logic        tick = 1'b0;
    logic        kill_valid = 1'b0;
    logic [0:0]  kill_player = '0;
    logic [2:0]  kill_slot = '0;
    logic [9:0]  valid;
    logic [59:0] shell_x, shell_y;
    logic [5:0]  count;
    logic [5:0]  disp_x = '0, disp_y = '0;
    logic        sprite_on = 1'b0;
    logic [47:0] palette = {24'hFF0000, 24'h00FF00};
    logic [23:0] rgb;

    int total = 0;
    int bad = 0;
    logic [23:0] exp_q[$];

    shell_table_render dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_spawn_valid(spawn_valid), .i_spawn_player(spawn_player),
        .i_spawn_x(spawn_x), .i_spawn_y(spawn_y), .i_spawn_dir(spawn_dir),
        .o_spawn_ready(spawn_ready),
        .i_tick(tick), .i_kill_valid(kill_valid), .i_kill_player(kill_player),
        .i_kill_slot(kill_slot),
        .o_valid(valid), .o_shell_x(shell_x), .o_shell_y(shell_y), .o_count(count),
        .i_display_x(disp_x), .i_display_y(disp_y), .i_sprite_on(sprite_on),
        .i_palette(palette), .o_rgb(rgb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sv;
        logic       sp;
        logic [5:0] sx, sy;
        logic [1:0] sd;
        logic       tk, kv, kp;
        logic [2:0] ks;
        logic       e_rdy;
        logic [9:0] e_val;
        int         e_c0, e_c1, cs, ex, ey;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(logic sv, logic sp, int sx, int sy, int sd,
                                logic tk, logic kv, logic kp, int ks,
                                logic e_rdy, logic [9:0] e_val, int c0, int c1,
                                int cs, int ex, int ey);
        vec_t v;
        v.sv = sv; v.sp = sp; v.sx = 6'(sx); v.sy = 6'(sy); v.sd = 2'(sd);
        v.tk = tk; v.kv = kv; v.kp = kp; v.ks = 3'(ks);
        v.e_rdy = e_rdy; v.e_val = e_val; v.e_c0 = c0; v.e_c1 = c1;
        v.cs = cs; v.ex = ex; v.ey = ey;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        spawn_valid = 1'b0; tick = 1'b0; kill_valid = 1'b0;
        spawn_player = '0; kill_player = '0; kill_slot = '0;
    endtask

    task automatic spawn_one(input logic p, input int x, input int y, input int d);
        spawn_valid = 1'b1; spawn_player = p;
        spawn_x = 6'(x); spawn_y = 6'(y); spawn_dir = 2'(d);
        @(posedge clk); #1;
        spawn_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = mk(1,0, 5, 5,1, 0,0,0,0, 1,10'h001,1,0, 0, 5, 5);
        tbl[1]  = mk(1,0, 5, 5,1, 0,0,0,0, 1,10'h003,2,0, 1, 5, 5);
        tbl[2]  = mk(1,0, 5, 5,1, 0,0,0,0, 1,10'h007,3,0, 2, 5, 5);
        tbl[3]  = mk(1,0, 5, 5,1, 0,0,0,0, 1,10'h00F,4,0, 3, 5, 5);
        tbl[4]  = mk(1,0, 5, 5,1, 0,0,0,0, 1,10'h01F,5,0, 4, 5, 5);
        tbl[5]  = mk(1,0, 5, 5,1, 0,0,0,0, 0,10'h01F,5,0, 4, 5, 5);
        tbl[6]  = mk(1,1,38, 3,1, 0,0,0,0, 1,10'h03F,5,1, 5,38, 3);
        tbl[7]  = mk(0,0, 0, 0,0, 1,0,0,0, 0,10'h03F,5,1, 5,39, 3);
        tbl[8]  = mk(0,0, 0, 0,0, 1,0,0,0, 0,10'h01F,5,0, 0, 7, 5);
        tbl[9]  = mk(1,1, 7, 0,0, 0,0,0,0, 1,10'h03F,5,1, 5, 7, 0);
        tbl[10] = mk(0,0, 0, 0,0, 1,0,0,0, 0,10'h01F,5,0, 2, 8, 5);
        tbl[11] = mk(1,0,20,20,2, 0,1,0,2, 0,10'h01B,4,0, 1, 8, 5);
        tbl[12] = mk(1,0,20,20,2, 1,0,0,0, 1,10'h01F,5,0, 2,20,20);
        tbl[13] = mk(0,0, 0, 0,0, 1,0,0,0, 0,10'h01F,5,0, 2,20,21);
        tbl[14] = mk(0,0, 0, 0,0, 1,1,0,0, 0,10'h01E,4,0, 1,11, 5);
        tbl[15] = mk(0,0, 0, 0,0, 0,1,1,3, 1,10'h01E,4,0, 1,11, 5);
        tbl[16] = mk(1,1,40, 0,0, 0,0,0,0, 1,10'h01E,4,0, 3,11, 5);
        tbl[17] = mk(1,1, 3,30,0, 0,0,0,0, 1,10'h01E,4,0, 4,11, 5);
        tbl[18] = mk(1,1,39,29,2, 0,0,0,0, 1,10'h03E,4,1, 5,39,29);
        tbl[19] = mk(0,0, 0, 0,0, 1,0,0,0, 1,10'h01E,4,0, 2,20,23);
        tbl[20] = mk(1,1, 0, 4,3, 0,0,0,0, 1,10'h03E,4,1, 5, 0, 4);
        tbl[21] = mk(0,0, 0, 0,0, 1,0,0,0, 1,10'h01E,4,0, 1,13, 5);
        tbl[22] = mk(1,1, 7, 3,0, 0,0,0,0, 1,10'h03E,4,1, 5, 7, 3);
        tbl[23] = mk(0,0, 0, 0,0, 1,0,0,0, 1,10'h03E,4,1, 5, 7, 2);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_rgb", 32'(rgb), 0);
        chk("rst_ready", 32'(spawn_ready), 1);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            spawn_valid = tbl[i].sv; spawn_player = tbl[i].sp;
            spawn_x = tbl[i].sx; spawn_y = tbl[i].sy; spawn_dir = tbl[i].sd;
            tick = tbl[i].tk; kill_valid = tbl[i].kv;
            kill_player = tbl[i].kp; kill_slot = tbl[i].ks;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(spawn_ready), 32'(tbl[i].e_rdy));
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), 32'(valid), 32'(tbl[i].e_val));
            chk($sformatf("v%0d_count0", i), 32'(count[2:0]), 32'(tbl[i].e_c0));
            chk($sformatf("v%0d_count1", i), 32'(count[5:3]), 32'(tbl[i].e_c1));
            chk($sformatf("v%0d_x", i), 32'(shell_x[tbl[i].cs*6 +: 6]), 32'(tbl[i].ex));
            chk($sformatf("v%0d_y", i), 32'(shell_y[tbl[i].cs*6 +: 6]), 32'(tbl[i].ey));
        end
        idle_inputs();

        // render: p0 slot0 and p1 slot0 both at (10,10), p1 slot1 at (1,1)
        do_reset();
        spawn_one(1'b0, 10, 10, 1);
        spawn_one(1'b1, 10, 10, 1);
        spawn_one(1'b1, 1, 1, 1);
        chk("render_setup_valid", 32'(valid), 32'h060 | 32'h001);
        begin
            int          px [7] = '{10, 10, 11, 10, 10, 10, 1};
            int          py [7] = '{10, 10, 10, 11, 10, 10, 1};
            logic        ps [7] = '{1, 0, 1, 1, 1, 1, 1};
            logic        pk [7] = '{0, 0, 0, 0, 1, 0, 0};
            logic [23:0] pe [7] = '{24'hFF0000, 24'h0, 24'h0, 24'h0,
                                    24'hFF0000, 24'h00FF00, 24'hFF0000};
            logic [23:0] e;
            for (int k = 0; k <= 7; k++) begin
                if (k < 7) begin
                    disp_x = 6'(px[k]); disp_y = 6'(py[k]); sprite_on = ps[k];
                    kill_valid = pk[k]; kill_player = 1'b1; kill_slot = 3'd0;
                    exp_q.push_back(pe[k]);
                end else begin
                    kill_valid = 1'b0;
                end
                @(posedge clk); #1;
                if (k >= 1) begin
                    e = exp_q.pop_front();
                    chk($sformatf("rgb_px%0d", k - 1), 32'(rgb), 32'(e));
                end
            end
        end

        // third live shell, then asynchronous reset between edges
        spawn_one(1'b0, 2, 2, 1);
        chk("pre_rst_rgb", 32'(rgb), 32'hFF0000);
        chk("pre_rst_valid", 32'(valid), 32'h043);
        chk("pre_rst_count", 32'(count), 32'h0A);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(valid), 0);
        chk("async_rst_count", 32'(count), 0);
        chk("async_rst_rgb", 32'(rgb), 0);
        sprite_on = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        spawn_one(1'b0, 4, 4, 0);
        chk("restart_valid", 32'(valid), 32'h001);
        chk("restart_count", 32'(count), 32'h01);
        chk("restart_x", 32'(shell_x[5:0]), 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
